// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexes the six alarm-clock digit patterns onto one shared
// active-low segment bus with six active-low digit enables. Each digit slot
// starts with a short all-off window to stop ghosting between digits, and the
// hh.mm.ss separator dots are lit on the minute-units and hour-units digits.
//
// Optional feature, enabled by defining the macro SEG_SCAN_BLINK_EN:
// digits selected by blink_mask are blanked on alternate groups of BLINK_DIV
// scan frames (time-set mode). Without the macro no blink state is built and
// blink_mask is ignored.
//
// Timing: every output is registered and reflects the scan state of the
// previous cycle. The counters hold still on the first edge after reset
// release, so cycle 0 is the first cycle in which scanning is running.

module seg_scan_driver #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4,
    parameter int BLINK_DIV = 128
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] secUSeg,
    input  logic [6:0] secTSeg,
    input  logic [6:0] minUSeg,
    input  logic [6:0] minTSeg,
    input  logic [6:0] hrUSeg,
    input  logic [6:0] hrTSeg,
    input  logic [5:0] blink_mask,
    output logic [5:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic       frame_tick
);

    localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [2:0]    slot;
    logic [6:0]    segLat;
    logic          running;
    logic          started;
    logic          cntWrap;
    logic [2:0]    nextSlot;
    logic [6:0]    nextPat;
    logic          blinkHide;
    logic          showDigit;

    // Prescaler wrap detection and selection of the pattern for the next slot
    always_comb begin
        cntWrap  = (cnt == CNT_LAST);
        nextSlot = (slot == 3'd5) ? 3'd0 : slot + 3'd1;
        nextPat  = secUSeg;
        case (nextSlot)
            3'd0:    nextPat = secUSeg;
            3'd1:    nextPat = secTSeg;
            3'd2:    nextPat = minUSeg;
            3'd3:    nextPat = minTSeg;
            3'd4:    nextPat = hrUSeg;
            3'd5:    nextPat = hrTSeg;
            default: nextPat = secUSeg;
        endcase
    end

    // Scan state: prescaler, slot index and the pattern latched for the slot
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            slot    <= 3'd0;
            segLat  <= secUSeg;
            running <= 1'b0;
            started <= 1'b0;
        end else begin
            running <= 1'b1;
            started <= running;
            if (running) begin
                if (cntWrap) begin
                    cnt    <= '0;
                    slot   <= nextSlot;
                    segLat <= nextPat;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blinkCnt;
    logic          blinkPhase;
    logic          maskLat;

    // Frame counter toggling the blink phase, and the mask bit of the current slot
    always_ff @(posedge clk) begin
        if (!resetn) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
            maskLat    <= blink_mask[0];
        end else if (running && cntWrap) begin
            maskLat <= blink_mask[nextSlot];
            if (slot == 3'd5) begin
                if (blinkCnt == BLINK_LAST) begin
                    blinkCnt   <= '0;
                    blinkPhase <= ~blinkPhase;
                end else begin
                    blinkCnt <= blinkCnt + 1'b1;
                end
            end
        end
    end

    assign blinkHide = blinkPhase & maskLat;
`else
    logic unusedBlinkMask;

    assign unusedBlinkMask = ^blink_mask;
    assign blinkHide       = 1'b0;
`endif

    // A digit is driven only past the anti-ghost window and when not blinked off
    always_comb begin
        showDigit = running && (cnt >= BLANK_END) && !blinkHide;
    end

    // Registered outputs so nothing combinational reaches the display pins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            an_n       <= 6'h3F;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= started && (cnt == '0) && (slot == 3'd0);
            if (showDigit) begin
                an_n  <= ~(6'b000001 << slot);
                seg_n <= ~segLat;
                dp_n  <= !((slot == 3'd2) || (slot == 3'd4));
            end else begin
                an_n  <= 6'h3F;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with SCAN_DIV = 8, BLANK_CYC = 2,
// BLINK_DIV = 2. Expected outputs for every cycle come from a hand-built
// timeline: slot s of frame f is displayed in cycles 48f+8s+3 .. 48f+8s+8.
// Blink expectations follow SEG_SCAN_BLINK_EN when the bench is built with it.

module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] secUSeg, secTSeg, minUSeg, minTSeg, hrUSeg, hrTSeg;
    logic [5:0] blink_mask;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    logic       frame_tick;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    // Enables per slot and inverted segment patterns for slots 1..5
    localparam logic [5:0] AN_TAB  [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    localparam logic [6:0] SEG_TAB [6] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

    seg_scan_driver #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .BLINK_DIV (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .secUSeg    (secUSeg),
        .secTSeg    (secTSeg),
        .minUSeg    (minUSeg),
        .minTSeg    (minTSeg),
        .hrUSeg     (hrUSeg),
        .hrTSeg     (hrTSeg),
        .blink_mask (blink_mask),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_tick (frame_tick)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [6:0] su, input logic [6:0] st,
                                 input logic [6:0] mu, input logic [6:0] mt,
                                 input logic [6:0] hu, input logic [6:0] ht,
                                 input logic [5:0] mask);
        secUSeg    = su;
        secTSeg    = st;
        minUSeg    = mu;
        minTSeg    = mt;
        hrUSeg     = hu;
        hrTSeg     = ht;
        blink_mask = mask;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 2 units after the edge
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic checkResetValues(input string where);
        checkOutput($sformatf("%s an_n", where), {2'b00, an_n}, 8'h3F);
        checkOutput($sformatf("%s seg_n", where), {1'b0, seg_n}, 8'h7F);
        checkOutput($sformatf("%s dp_n", where), {7'b0, dp_n}, 8'h01);
        checkOutput($sformatf("%s frame_tick", where), {7'b0, frame_tick}, 8'h00);
    endtask

    // Expected outputs in cycle t; seg0First is slot 0's bus value in frame 0
    function automatic void expectAt(input int t, input logic [6:0] seg0First,
                                     output logic [5:0] an, output logic [6:0] seg,
                                     output logic dp, output logic tk);
        int u, f, s, c;
        an  = 6'h3F;
        seg = 7'h7F;
        dp  = 1'b1;
        tk  = 1'b0;
        if (t >= 1) begin
            u  = t - 1;
            f  = u / 48;
            s  = (u % 48) / 8;
            c  = u % 8;
            tk = (t >= 49) && (s == 0) && (c == 0);
            if ((c >= 2) && !(BLINK_ON && (s == 0) && (((f / 2) % 2) == 1))) begin
                an  = AN_TAB[s];
                seg = (s != 0) ? SEG_TAB[s] : ((f == 0) ? seg0First : 7'h40);
                dp  = !((s == 2) || (s == 4));
            end
        end
    endfunction

    // Check every cycle from the current one up to and including 'last'
    task automatic runTo(input int last, input logic [6:0] seg0First);
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tk;
        forever begin
            expectAt(cyc, seg0First, an, seg, dp, tk);
            checkOutput($sformatf("c%0d an_n", cyc), {2'b00, an_n}, {2'b00, an});
            checkOutput($sformatf("c%0d seg_n", cyc), {1'b0, seg_n}, {1'b0, seg});
            checkOutput($sformatf("c%0d dp_n", cyc), {7'b0, dp_n}, {7'b0, dp});
            checkOutput($sformatf("c%0d frame_tick", cyc), {7'b0, frame_tick}, {7'b0, tk});
            if (cyc >= last) break;
            step();
        end
    endtask

    // Release reset so that the next edge is the one ending the reset phase
    task automatic releaseReset();
        resetn = 1'b1;
        @(posedge clk);
        #2;
        cyc = 0;
    endtask

    initial begin
        $display("[TB] seg_scan_driver bench start");
        resetn = 1'b0;
        applyStimulus(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 6'h01);

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #2;
        checkResetValues("reset");

        // Scan order, colons, frame ticks and blink over five frames
        releaseReset();
        runTo(5, 7'h79);
        applyStimulus(7'h3F, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 6'h01);
        step();
        runTo(200, 7'h79);

        // Reset asserted in the middle of slot 3
        resetn = 1'b0;
        step();
        releaseReset();
        runTo(29, 7'h40);
        resetn = 1'b0;
        step();
        checkResetValues("midreset");
        step();
        step();
        checkResetValues("midreset hold");

        // Scanning restarts at slot 0 with the currently applied secU pattern
        releaseReset();
        runTo(12, 7'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Downstream display stage of the alarm clock. It consumes the six 7-segment patterns produced by `alarm_clock` (`secUSeg` … `hrTSeg`) and time-multiplexes them onto one shared, active-low segment bus with six active-low digit enables. It adds anti-ghosting blanking between digits, colon dots, and an optional blink of selected digits for time-set mode.

## Interface
- `SCAN_DIV`, default 1000: clk cycles per digit slot; legal range ≥ 2.
- `BLANK_CYC`, default 4: cycles at the start of each slot with all digits off; legal range 0 ≤ BLANK_CYC < SCAN_DIV.
- `BLINK_DIV`, default 128: scan frames per blink half-period; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `secUSeg`, `secTSeg`, `minUSeg`, `minTSeg`, `hrUSeg`, `hrTSeg`  in  7 each  segment patterns, active-high (1 = lit), bit 0 = segment a.
- `blink_mask`  in  6  bit k = 1 blinks digit slot k.
- `an_n`  out  6  digit enables, active-low; bit k = slot k.
- `seg_n`  out  7  segment bus, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `frame_tick`  out  1  one-cycle pulse at the start of each scan frame.

## Operation
- Slot order: 0 = secU, 1 = secT, 2 = minU, 3 = minT, 4 = hrU, 5 = hrT.
- Prescaler `cnt` counts 0 … SCAN_DIV−1 and wraps to 0.
- `slot` advances on each wrap and goes from 5 back to 0.
- One frame lasts 6·SCAN_DIV cycles.
- On the edge that advances to slot s, `seg_lat` captures the pattern for slot s.
  - Input changes inside a slot are not visible until that slot's next capture.
- Blank window (`cnt` < BLANK_CYC): `an_n` = 6'h3F, `seg_n` = 7'h7F, `dp_n` = 1.
- Active window (`cnt` ≥ BLANK_CYC):
  - `an_n` = ~(1 << slot).
  - `seg_n` = ~seg_lat.
  - `dp_n` = 0 only in slots 2 and 4 (hh.mm.ss separators), otherwise 1.
- `frame_tick` = 1 exactly when `cnt` = 0 and `slot` = 0, excluding the first cycle after reset release.
- All outputs come from flops. No combinational path runs from the inputs to the outputs.

## Timing
- Reset, applied on any clk edge with `resetn` = 0:
  - `cnt` = 0, `slot` = 0, `seg_lat` = `secUSeg`.
  - `an_n` = 6'h3F, `seg_n` = 7'h7F, `dp_n` = 1, `frame_tick` = 0.
  - Blink counter = 0 and blink phase = 0 (visible).
- Cycle 0 is the first cycle after an edge that samples `resetn` = 1.
- Slot s occupies cycles [s·SCAN_DIV, (s+1)·SCAN_DIV). Its active window starts at cycle s·SCAN_DIV + BLANK_CYC + 1, one cycle of register latency.
- The first `frame_tick` pulse occurs in cycle 6·SCAN_DIV + 1. After that it repeats every 6·SCAN_DIV cycles.
- Capture-to-display latency is BLANK_CYC + 1 cycles.
- Reset mid-scan: outputs return to reset values on the next edge and scanning restarts at slot 0. No partial slot is completed.
- With BLANK_CYC = 0, the only blanking is the one-cycle latency between slot change and the outputs.

## Configuration
- Macro: `SEG_SCAN_BLINK_EN`.
- Defined:
  - A blink counter counts frames 0 … BLINK_DIV−1 and toggles the blink phase on each wrap.
  - While the phase is 1 and `blink_mask[slot]` = 1, the active window behaves as a blank window: `an_n` = 6'h3F, `seg_n` = 7'h7F, `dp_n` = 1.
  - Unmasked slots are unaffected.
  - `blink_mask` is sampled at the slot capture edge.
- Undefined:
  - No blink counter or phase flops are built.
  - `blink_mask` is ignored.
  - Every slot always displays.

## Test plan
All scenarios use SCAN_DIV = 8, BLANK_CYC = 2, BLINK_DIV = 2.
- Reset: hold `resetn` = 0 for 3 cycles → `an_n` = 6'h3F, `seg_n` = 7'h7F, `dp_n` = 1, `frame_tick` = 0.
- Scan order: inputs secU = 7'h06, secT = 7'h5B, minU = 7'h4F, minT = 7'h66, hrU = 7'h6D, hrT = 7'h7D.
  - Cycles 0–2: `an_n` = 6'h3F.
  - Cycles 3–8: `an_n` = 6'h3E, `seg_n` = 7'h79.
  - Cycles 11–16: `an_n` = 6'h3D, `seg_n` = 7'h24.
  - …continuing for each slot; `frame_tick` pulses at cycles 49, 97, ….
- Mid-slot change: set secU = 7'h3F at cycle 5 → `seg_n` stays 7'h79 through cycle 8, then shows 7'h40 from cycle 51.
- Colons: over one frame, `dp_n` = 0 only in cycles 19–24 (slot 2) and 35–40 (slot 4).
- Blink:
  - With `SEG_SCAN_BLINK_EN` defined and `blink_mask` = 6'h01: slot 0 is lit in frames 0–1, `an_n` stays 6'h3F during slot 0 of frames 2–3, and slots 1–5 show normally.
  - With the macro undefined: slot 0 is lit in every frame.
- Reset mid-operation: drive `resetn` = 0 during cycle 29 (slot 3) → at the next edge all outputs take their reset values; after release, slot 0 re-displays starting at cycle 3.
